// File: rtl/rev_serial_alu_if.sv
// Bundles the operation request and result signals of rev_serial_alu.
//   start/op/a/b          : request side, driven by the master
//   busy/done/result/
//   cout/zero             : status and result side, driven by the ALU (slave)
interface rev_serial_alu_if #(
  parameter int unsigned WIDTH = 32
);

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             zero;

  modport master (
    output start, op, a, b,
    input  busy, done, result, cout, zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, cout, zero
  );

endinterface

// File: rtl/rev_serial_alu.sv
// Bit-serial ALU built from reversible Peres cells. One operand bit is
// resolved per clock, LSB first, so an operation takes WIDTH cycles in RUN
// followed by a single DONE cycle that pulses done.
//
// Ports:
//   clk  : clock, all state changes on the rising edge
//   rst  : synchronous active-high reset
//   bus  : rev_serial_alu_if slave modport
//          start  - request, sampled only in IDLE
//          op     - 00 ADD, 01 SUB, 10 AND, 11 XOR
//          a, b   - operands, captured when start is accepted
//          busy   - high for the WIDTH cycles spent in RUN
//          done   - one-cycle pulse, result/cout/zero valid from then on
//          result - registered result, held until the next acceptance
//          cout   - final carry for ADD/SUB (SUB: 1 = no borrow), 0 otherwise
//          zero   - result == 0, registered together with result
module rev_serial_alu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  rev_serial_alu_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [CNT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [1:0]       op_reg;
  logic             carry;

  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] result_r;
  logic             cout_r;
  logic             zero_r;

  logic             accept;
  logic             last_bit;
  logic             is_arith;
  logic             q1;
  logic             r1;
  logic             q2;
  logic             r2;
  logic             bit_res;
  logic [WIDTH-1:0] res_next;

  // Peres cell (P=A, Q=A^B, R=(A&B)^C); P is a pass-through of A and is not
  // needed downstream, so only {Q,R} is returned.
  function automatic logic [1:0] peres_qr(input logic pa, input logic pb, input logic pc);
    return {pa ^ pb, (pa & pb) ^ pc};
  endfunction

  assign accept   = (state == ST_IDLE) && bus.start;
  assign last_bit = (bit_cnt == CNT_W'(WIDTH - 1));
  assign is_arith = ~op_reg[1];

  // Two cascaded Peres cells: first gives a^b and a&b, second folds in the carry.
  always_comb begin
    {q1, r1} = peres_qr(a_sr[0], b_sr[0], 1'b0);
    {q2, r2} = peres_qr(q1, carry, r1);
  end

  // Per-bit result selection by operation.
  always_comb begin
    bit_res = 1'b0;
    case (op_reg)
      OP_ADD, OP_SUB: bit_res = q2;
      OP_AND:         bit_res = r1;
      OP_XOR:         bit_res = q1;
      default:        bit_res = 1'b0;
    endcase
  end

  // Result shift register after this edge's bit is shifted in at the MSB.
  assign res_next = {bit_res, res_sr[WIDTH-1:1]};

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (bus.start) state_next = ST_RUN;
      ST_RUN:  if (last_bit)  state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // State register with registered busy/done decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      state  <= state_next;
      busy_r <= (state_next == ST_RUN);
      done_r <= (state_next == ST_DONE);
    end
  end

  // Operand capture, serial datapath and result publication.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt  <= '0;
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      op_reg   <= OP_ADD;
      carry    <= 1'b0;
      result_r <= '0;
      cout_r   <= 1'b0;
      zero_r   <= 1'b1;
    end else if (accept) begin
      // SUB is a + ~b + 1: invert b and preload the carry.
      a_sr    <= bus.a;
      b_sr    <= (bus.op == OP_SUB) ? ~bus.b : bus.b;
      op_reg  <= bus.op;
      carry   <= (bus.op == OP_SUB);
      bit_cnt <= '0;
      res_sr  <= '0;
    end else if (state == ST_RUN) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= res_next;
      if (is_arith) begin
        carry <= r2;
      end
      if (last_bit) begin
        result_r <= res_next;
        cout_r   <= is_arith ? r2 : 1'b0;
        zero_r   <= (res_next == '0);
      end else begin
        // Counter saturates at WIDTH-1; the FSM leaves RUN on that edge.
        bit_cnt <= bit_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.result = result_r;
  assign bus.cout   = cout_r;
  assign bus.zero   = zero_r;

endmodule

// File: tb/tb_rev_serial_alu.sv
// Directed bench for rev_serial_alu (WIDTH=32 and WIDTH=8 instances) using a
// scoreboard queue of expected results.
module tb_rev_serial_alu;

  logic clk = 1'b0;
  logic rst;

  rev_serial_alu_if #(.WIDTH(32)) bus ();
  rev_serial_alu_if #(.WIDTH(8))  bus8 ();

  rev_serial_alu #(.WIDTH(32)) dut  (.clk(clk), .rst(rst), .bus(bus));
  rev_serial_alu #(.WIDTH(8))  dut8 (.clk(clk), .rst(rst), .bus(bus8));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        cout;
    logic        zero;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    tests++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(input logic [31:0] res, input logic cout, input logic zero);
    exp_t e;
    e.res = res; e.cout = cout; e.zero = zero;
    return e;
  endfunction

  // Independent reference: word-level arithmetic, not bit-serial.
  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    case (op)
      2'b00:   s = {1'b0, a} + {1'b0, b};
      2'b01:   s = {1'b0, a} + {1'b0, ~b} + 33'd1;
      2'b10:   s = {1'b0, a & b};
      default: s = {1'b0, a ^ b};
    endcase
    return mk(s[31:0], s[32], s[31:0] == 32'd0);
  endfunction

  // Issue one operation on the 32-bit instance and check it against the
  // scoreboard. repulse_at >= 0 raises start again during that RUN cycle.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input exp_t want, input int repulse_at);
    int   lat;
    int   busy_cnt;
    int   extra_done;
    exp_t got;
    sb.push_back(want);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    tick();
    bus.start = 1'b0;
    bus.a = $urandom; bus.b = $urandom; bus.op = 2'($urandom);
    lat = 0; busy_cnt = 0;
    while (bus.done !== 1'b1 && lat < 100) begin
      if (bus.busy === 1'b1) busy_cnt++;
      bus.start = (lat == repulse_at);
      tick();
      lat++;
    end
    bus.start = 1'b0;
    check({tag, " done_seen"}, 32'(bus.done), 32'd1);
    check({tag, " latency"}, 32'(lat), 32'd32);
    check({tag, " busy_cycles"}, 32'(busy_cnt), 32'd32);
    check({tag, " busy_in_done"}, 32'(bus.busy), 32'd0);
    got = sb.pop_front();
    check({tag, " result"}, bus.result, got.res);
    check({tag, " cout"}, 32'(bus.cout), 32'(got.cout));
    check({tag, " zero"}, 32'(bus.zero), 32'(got.zero));
    extra_done = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.done === 1'b1) extra_done++;
    end
    check({tag, " single_done"}, 32'(extra_done), 32'd0);
    check({tag, " result_hold"}, bus.result, got.res);
  endtask

  initial begin
    int   lat;
    int   dcnt;
    exp_t e;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [1:0]  rop;

    bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
    bus8.start = 1'b0; bus8.op = 2'b00; bus8.a = '0; bus8.b = '0;

    // Reset with a coincident start, which must be ignored.
    rst = 1'b1;
    bus.start = 1'b1; bus.a = 32'hDEAD; bus.b = 32'hBEEF;
    tick();
    tick();
    bus.start = 1'b0;
    rst = 1'b0;
    tick();
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset result", bus.result, 32'd0);
    check("reset cout", 32'(bus.cout), 32'd0);
    check("reset zero", 32'(bus.zero), 32'd1);

    // Directed arithmetic and logic vectors.
    run_op("add_1_2",   2'b00, 32'h00000001, 32'h00000002, mk(32'h00000003, 1'b0, 1'b0), -1);
    run_op("add_wrap",  2'b00, 32'hFFFFFFFF, 32'h00000001, mk(32'h00000000, 1'b1, 1'b1), -1);
    run_op("sub_eq",    2'b01, 32'h12345678, 32'h12345678, mk(32'h00000000, 1'b1, 1'b1), -1);
    run_op("sub_borrow",2'b01, 32'h00000000, 32'h00000001, mk(32'hFFFFFFFF, 1'b0, 1'b0), -1);
    run_op("and",       2'b10, 32'hFFFFFFFF, 32'hAAAAAAAA, mk(32'hAAAAAAAA, 1'b0, 1'b0), -1);
    run_op("xor",       2'b11, 32'h12345678, 32'h9ABCDEF0, mk(32'h88888888, 1'b0, 1'b0), -1);

    // Start re-pulsed at bit 5 is ignored.
    run_op("add_repulse", 2'b00, 32'h5, 32'h5, mk(32'h0000000A, 1'b0, 1'b0), 5);

    // A few random operations checked against the word-level model.
    for (int i = 0; i < 4; i++) begin
      ra = $urandom; rb = $urandom; rop = 2'(i);
      run_op("rand", rop, ra, rb, model(rop, ra, rb), -1);
    end

    // Abort at bit 10 with reset: no done pulse, outputs cleared.
    bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'h0000FFFF; bus.b = 32'h00000123;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort busy", 32'(bus.busy), 32'd0);
    check("abort done", 32'(bus.done), 32'd0);
    check("abort result", bus.result, 32'd0);
    check("abort zero", 32'(bus.zero), 32'd1);
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done === 1'b1 || bus.busy === 1'b1) dcnt++;
      tick();
    end
    check("abort no_done", 32'(dcnt), 32'd0);

    // First start after reset is accepted normally.
    run_op("add_3_4", 2'b00, 32'h3, 32'h4, mk(32'h00000007, 1'b0, 1'b0), -1);

    // 8-bit instance: ADD 0xFF + 0x01.
    sb.push_back(mk(32'h00, 1'b1, 1'b1));
    bus8.start = 1'b1; bus8.op = 2'b00; bus8.a = 8'hFF; bus8.b = 8'h01;
    tick();
    bus8.start = 1'b0; bus8.a = 8'h55; bus8.b = 8'h33;
    lat = 0;
    while (bus8.done !== 1'b1 && lat < 50) begin
      tick();
      lat++;
    end
    e = sb.pop_front();
    check("w8 done_seen", 32'(bus8.done), 32'd1);
    check("w8 latency", 32'(lat), 32'd8);
    check("w8 result", 32'(bus8.result), e.res);
    check("w8 cout", 32'(bus8.cout), 32'(e.cout));
    check("w8 zero", 32'(bus8.zero), 32'(e.zero));
    check("sb empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rev_serial_alu.md
REV_SERIAL_ALU -- requirements
Module: rev_serial_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the operand and result width in bits (WIDTH >= 2).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port rst, input, 1, the reset, which is synchronous and active-high.
REQ-004 SHALL have port start, input, 1, an operation request, sampled only in IDLE.
REQ-005 SHALL have port op, input, 2, the operation: 00 ADD, 01 SUB, 10 AND, 11 XOR.
REQ-006 SHALL have port a, input, WIDTH, operand A, captured when start is accepted.
REQ-007 SHALL have port b, input, WIDTH, operand B, captured when start is accepted.
REQ-008 SHALL have port busy, output, 1, high while bits are being processed.
REQ-009 SHALL have port done, output, 1, a one-cycle pulse that marks result, cout and zero as valid.
REQ-010 SHALL have port result, output, WIDTH, the registered operation result.
REQ-011 SHALL have port cout, output, 1, the final carry for ADD/SUB and 0 for logic ops.
REQ-012 SHALL have port zero, output, 1, high when result == 0, registered with result.

Function
REQ-013 SHALL implement an FSM with states IDLE, RUN and DONE.
- IDLE->RUN on start.
- RUN->DONE after WIDTH bit steps.
- DONE->IDLE unconditionally after one cycle.
REQ-014 On acceptance (edge N), SHALL latch the operands and op and clear the bit counter.
- SUB: latch ~b and preload carry = 1.
- Otherwise: latch b and preload carry = 0.
REQ-015 In RUN, SHALL process one bit per edge, LSB first: bit i is resolved at edge N+1+i, for i = 0..WIDTH-1.
REQ-016 Each bit SHALL be computed by two cascaded Peres cells (P=A, Q=A^B, R=(A&B)^C).
- Cell 1: inputs (a_i, b_i, 0), giving Q1 = a_i^b_i and R1 = a_i&b_i.
- Cell 2: inputs (Q1, carry, R1), giving Q2 = sum_i and R2 = carry_out.
REQ-017 Per-bit result selection:
- ADD/SUB: result bit = Q2, and carry <= R2.
- AND: result bit = R1.
- XOR: result bit = Q1.
- AND and XOR leave carry unchanged.
REQ-018 Operand and result shift registers SHALL shift right one position per RUN edge, so the result is fully assembled at edge N+WIDTH.
REQ-019 busy SHALL be 1 exactly while in RUN: from after edge N until edge N+WIDTH, which is WIDTH cycles.
REQ-020 done SHALL be 1 for exactly one cycle, in DONE (after edge N+WIDTH); result, cout and zero are valid from then until the next acceptance.
REQ-021 cout SHALL equal the final carry for ADD/SUB; for SUB, 1 means no borrow. For AND/XOR, cout SHALL be 0.
REQ-022 SHALL ignore start while in RUN or DONE, with no effect on state, counter or outputs.
REQ-023 Changes on a, b or op after acceptance SHALL NOT affect the operation in progress.
REQ-024 Between operations, result, cout and zero SHALL hold their last values.
REQ-025 Bit-counter wrap: the counter SHALL count 0..WIDTH-1 and SHALL NOT wrap to re-enter RUN.

Reset
REQ-026 While rst = 1, the block SHALL reach the following at the next edge:
- state = IDLE
- busy = 0, done = 0
- result = 0, cout = 0, zero = 1
- counter, carry and operand registers = 0
REQ-027 Reset asserted mid-RUN or in DONE SHALL abort the operation, with no done pulse.
REQ-028 A start coincident with rst SHALL be ignored; rst has priority.
REQ-029 The first start after rst deasserts SHALL be accepted normally.

Verification
REQ-030 ADD: a=0x00000001, b=0x00000002 -> done exactly 32 edges after acceptance; result=0x00000003, cout=0, zero=0; busy high for 32 cycles.
REQ-031 ADD wrap-around: a=0xFFFFFFFF, b=0x00000001 -> result=0x00000000, cout=1, zero=1.
REQ-032 SUB, two cases:
- a=0x12345678, b=0x12345678 -> result=0x00000000, cout=1, zero=1.
- a=0x00000000, b=0x00000001 -> result=0xFFFFFFFF, cout=0.
REQ-033 Logic ops:
- AND with a=0xFFFFFFFF, b=0xAAAAAAAA -> result=0xAAAAAAAA, cout=0.
- XOR with a=0x12345678, b=0x9ABCDEF0 -> result=0x88888888, cout=0.
REQ-034 Protocol:
- start with ADD 0x5+0x5, then re-pulse start with new operands at bit 5 -> result=0x0000000A, with exactly one done pulse.
- rst at bit 10 of a second operation -> busy=0, result=0, zero=1, no done.
- A following ADD 0x3+0x4 -> 0x00000007.
REQ-035 WIDTH=8 build: ADD a=0xFF, b=0x01 -> result=0x00, cout=1, zero=1, with done 8 edges after acceptance.
